// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC/fetch stage: FSM encodings, reset PC and
// pipeline stall constants.
package pc_fetch_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
    localparam logic [31:0] ZeroWord         = 32'h0000_0000;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
interface pc_fetch_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_ack,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_ack,
        output inst_rdata
    );

endinterface

// File: rtl/pc_fetch_pc_next_mux.sv
// Next-PC selection when leaving S_DONE: pending redirect, then a same-cycle
// branch, then sequential advance (wraps modulo 2^32).
module pc_next_mux
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
) (
    input  logic        pend_valid_i,
    input  logic [31:0] pend_target_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o
);

    always_comb begin
        if (pend_valid_i) begin
            pc_next_o = pend_target_i;
        end else if (branch_i) begin
            pc_next_o = branch_target_i;
        end else begin
            pc_next_o = pc_i + PC_STEP;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// PC register and instruction fetch FSM: one outstanding request at a time,
// redirects during an outstanding request are deferred until its ack.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [5:0]        stall,
    input  logic              branch_flag,
    input  logic [31:0]       branch_target_address,
    pc_fetch_if.master        imem,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_inst,
    output logic              stallreq_if
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        kill_q, kill_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] pc_seq_next;
    logic        stall_unused;

    assign stall_unused = ^stall[5:1];

    pc_next_mux #(
        .PC_STEP (PC_STEP)
    ) u_next_mux (
        .pend_valid_i    (pend_vld_q),
        .pend_target_i   (pend_tgt_q),
        .branch_i        (branch_flag),
        .branch_target_i (branch_target_address),
        .pc_i            (pc_q),
        .pc_next_o       (pc_seq_next)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        kill_d     = kill_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem.inst_ack) begin
                    // A killed response is dropped and the redirect is issued
                    // as a fresh request; a same-cycle branch is the newest target.
                    if (kill_q || branch_flag) begin
                        pc_d       = branch_flag ? branch_target_address : pend_tgt_q;
                        kill_d     = 1'b0;
                        pend_vld_d = 1'b0;
                    end else begin
                        buf_d   = imem.inst_rdata;
                        state_d = S_DONE;
                    end
                end else if (branch_flag) begin
                    kill_d     = 1'b1;
                    pend_vld_d = 1'b1;
                    pend_tgt_d = branch_target_address;
                end
            end
            S_DONE: begin
                if (stall[0] == Stop) begin
                    if (branch_flag) begin
                        pend_vld_d = 1'b1;
                        pend_tgt_d = branch_target_address;
                    end
                end else begin
                    pc_d       = pc_seq_next;
                    pend_vld_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            buf_q      <= ZeroWord;
            kill_q     <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= ZeroWord;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            kill_q     <= kill_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign imem.inst_req  = (state_q == S_REQ);
    assign imem.inst_addr = pc_q;
    assign stallreq_if    = (state_q == S_REQ);
    assign if_pc          = pc_q;
    assign if_inst        = (state_q == S_DONE) ? buf_q : ZeroWord;

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000, the first fetch address after reset.
REQ-002 Parameter PC_STEP, default 32'd4, the sequential PC increment.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 resetn  in  1  reset, asynchronous, active-high (1 = reset asserted), despite the name.
REQ-005 stall  in  6  pipeline stall vector from the stall controller; bit 0 = PC/fetch stage, 1 = Stop.
REQ-006 branch_flag  in  1  single-cycle redirect strobe from ID.
REQ-007 branch_target_address  in  32  redirect target, valid with branch_flag.
REQ-008 inst_req  out  1  instruction-memory request.
REQ-009 inst_addr  out  32  instruction-memory address, stable while inst_req=1.
REQ-010 inst_ack  in  1  memory response strobe; inst_rdata valid same cycle.
REQ-011 inst_rdata  in  32  fetched instruction word.
REQ-012 if_pc  out  32  PC of the instruction presented to IF_ID.
REQ-013 if_inst  out  32  instruction presented to IF_ID; 0 (bubble) when none valid.
REQ-014 stallreq_if  out  1  fetch-not-ready request to the stall controller.

Function
REQ-015 FSM states: S_IDLE, S_REQ, S_DONE; a registered pc, a 32-bit instruction buffer, a kill flag, and a pending-redirect register (valid bit + 32-bit target).
REQ-016 S_IDLE lasts exactly one cycle after reset deassertion, then S_REQ with inst_addr=pc.
REQ-017 S_REQ: inst_req=1, inst_addr=pc, stallreq_if=1, if_inst=0, if_pc=pc; remains until inst_ack=1 (latency 1..N cycles, unbounded).
REQ-018 S_REQ with inst_ack=1 and kill=0: capture inst_rdata into buffer, go S_DONE.
REQ-019 S_DONE: inst_req=0, stallreq_if=0, if_pc=pc, if_inst=buffer.
REQ-020 S_DONE with stall[0]=0: pc <= pending target if pending valid, else branch_target_address if branch_flag=1, else pc+PC_STEP (mod 2^32, wrap from FFFFFFFC to 00000000); clear pending; go S_REQ.
REQ-021 S_DONE with stall[0]=1: hold pc and buffer; a branch_flag in this cycle is latched into pending (a later flag overwrites an earlier one).
REQ-022 branch_flag in S_REQ with no ack same cycle: set kill, latch target into pending; inst_req and inst_addr remain unchanged until the outstanding ack.
REQ-023 S_REQ with inst_ack=1 and kill=1 (or branch_flag=1 same cycle): discard inst_rdata, pc <= redirect target, clear kill and pending, stay S_REQ; the new address appears on inst_addr the next cycle.
REQ-024 At most one outstanding memory request; inst_addr never changes while a request is unacknowledged.
REQ-025 inst_ack outside S_REQ is ignored.
REQ-026 Target alignment is not checked; low address bits pass through unchanged.

Reset
REQ-027 While resetn=1: state=S_IDLE, pc=RESET_PC, buffer=0, kill=0, pending cleared; outputs inst_req=0, inst_addr=RESET_PC, if_pc=RESET_PC, if_inst=0, stallreq_if=0.
REQ-028 Reset asserted mid-request abandons the request; a late inst_ack after reset is ignored until S_REQ is re-entered, then treated as the fresh response.

Structure
REQ-029 State encodings, RESET_PC default, ZeroWord and Stop/NoStop constants belong in the shared define package.
REQ-030 One sub-module is natural: pc_next_mux (combinational next-PC selection among pending, branch, and sequential).
REQ-031 Output drive is registered or a direct decode of registered state; there are no combinational paths from inst_ack to inst_req.

Verification
REQ-032 Reset released, ack latency 1, stall=0 -> inst_addr sequence BFC00000, BFC00004, BFC00008; if_inst matches memory; stallreq_if=1 exactly during each S_REQ cycle.
REQ-033 Ack latency 3 -> stallreq_if high 3 cycles per fetch; if_inst=0 during the wait; no address change while waiting.
REQ-034 branch_flag=1, target 80000100, while in S_DONE with stall[0]=1 for 4 cycles -> pc held; after stall release next inst_addr=80000100.
REQ-035 branch_flag in S_REQ before ack -> returned word discarded (never on if_inst), next inst_addr=target.
REQ-036 pc=FFFFFFFC, sequential advance -> next inst_addr=00000000.
REQ-037 Reset asserted during S_REQ, ack arrives during reset -> outputs at reset values; first post-reset fetch at BFC00000.
